// File: rtl/debounce_pkg.sv
// Purpose : shared types and elaboration helpers for the debounce controller.
// Latency : n/a (package only).
// Backpressure: n/a; provides channel state encoding, prescaler divide and clog2.
package debounce_pkg;

   // Bit 1 of the encoding is the debounced level: the level output is a
   // straight decode of the state flops.
   typedef enum logic [1:0] {
      IDLE_LO = 2'b00,
      PEND_HI = 2'b01,
      PEND_LO = 2'b10,
      IDLE_HI = 2'b11
   } deb_state_e;

   // Ceiling log2, never below 1 so it is always usable as a vector width.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // Clocks per sample tick.
   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/debounce_tick_ctrl_if.sv
// Purpose : bundles enable, raw buttons, sample tick and debounced outputs.
// Latency : n/a (wiring only).
// Backpressure: none; outputs are levels and single-cycle pulses.
// Ports   : enable, btn_in (master -> slave); tick, btn_level, btn_rise,
//           btn_fall (slave -> master).
interface debounce_tick_ctrl_if #(
   parameter int NUM_CH = 4
);
   logic              enable;
   logic [NUM_CH-1:0] btn_in;
   logic              tick;
   logic [NUM_CH-1:0] btn_level;
   logic [NUM_CH-1:0] btn_rise;
   logic [NUM_CH-1:0] btn_fall;

   modport master (
      output enable, btn_in,
      input  tick, btn_level, btn_rise, btn_fall
   );

   modport slave (
      input  enable, btn_in,
      output tick, btn_level, btn_rise, btn_fall
   );
endinterface

// File: rtl/debounce_chan.sv
// Purpose : one debounce channel: 2-flop synchronizer, qualify FSM, edge pulses.
// Latency : 2 clks sync + STABLE_TICKS ticks (+ tick phase) + 1 clk to level/pulse.
// Backpressure: none; state advances only on cycles with tick=1, otherwise holds.
// Ports   : clk_in, reset (async, active-high), tick, btn_raw in;
//           level, rise, fall out.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int STABLE_TICKS = 4
) (
   input  logic clk_in,
   input  logic reset,
   input  logic tick,
   input  logic btn_raw,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int               CNT_W    = clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync_a;
   logic             sync_b;
   deb_state_e       state;
   deb_state_e       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic             rise_nxt;
   logic             fall_nxt;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state <= IDLE_LO;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         rise  <= rise_nxt;
         fall  <= fall_nxt;
      end
   end

   assign cnt_inc = cnt + CNT_ONE;

   // Pulses are only produced on tick cycles and ticks are never adjacent,
   // so rise/fall are one clock wide without extra edge detection.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      if (tick) begin
         unique case (state)
            IDLE_LO: if (sync_b) begin
               if (CNT_ONE == CNT_LAST) begin
                  state_nxt = IDLE_HI;
                  rise_nxt  = 1'b1;
               end else begin
                  state_nxt = PEND_HI;
                  cnt_nxt   = CNT_ONE;
               end
            end
            PEND_HI: if (sync_b) begin
               if (cnt_inc == CNT_LAST) begin
                  state_nxt = IDLE_HI;
                  cnt_nxt   = '0;
                  rise_nxt  = 1'b1;
               end else begin
                  cnt_nxt   = cnt_inc;
               end
            end else begin
               // A bounce back to the old level restarts qualification.
               state_nxt = IDLE_LO;
               cnt_nxt   = '0;
            end
            IDLE_HI: if (!sync_b) begin
               if (CNT_ONE == CNT_LAST) begin
                  state_nxt = IDLE_LO;
                  fall_nxt  = 1'b1;
               end else begin
                  state_nxt = PEND_LO;
                  cnt_nxt   = CNT_ONE;
               end
            end
            PEND_LO: if (!sync_b) begin
               if (cnt_inc == CNT_LAST) begin
                  state_nxt = IDLE_LO;
                  cnt_nxt   = '0;
                  fall_nxt  = 1'b1;
               end else begin
                  cnt_nxt   = cnt_inc;
               end
            end else begin
               state_nxt = IDLE_HI;
               cnt_nxt   = '0;
            end
            default: begin
               state_nxt = IDLE_LO;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign level = state[1];

endmodule

// File: rtl/debounce_tick_ctrl.sv
// Purpose : shared sample-tick prescaler plus NUM_CH debounce channels.
// Latency : tick DIV clks after enable rises; level/pulses per debounce_chan.
// Backpressure: none; enable=0 clears the prescaler and freezes all channels.
// Ports   : clk_in, reset (async, active-high); bus (slave): enable, btn_in in;
//           tick, btn_level, btn_rise, btn_fall out.
module debounce_tick_ctrl
   import debounce_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int TICK_HZ      = 500,
   parameter int NUM_CH       = 4,
   parameter int STABLE_TICKS = 4
) (
   input logic                 clk_in,
   input logic                 reset,
   debounce_tick_ctrl_if.slave bus
);
   localparam int               DIV      = calc_div(CLK_HZ, TICK_HZ);
   localparam int               PRE_W    = clog2(DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   logic [PRE_W-1:0]  pre_cnt;
   logic              tick_q;
   logic [NUM_CH-1:0] level_v;
   logic [NUM_CH-1:0] rise_v;
   logic [NUM_CH-1:0] fall_v;

   // Tick is registered: it goes high in the cycle after the terminal count.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         pre_cnt <= '0;
         tick_q  <= 1'b0;
      end else if (!bus.enable) begin
         pre_cnt <= '0;
         tick_q  <= 1'b0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
         tick_q  <= 1'b1;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
         tick_q  <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_chan #(
         .STABLE_TICKS (STABLE_TICKS)
      ) u_chan (
         .clk_in  (clk_in),
         .reset   (reset),
         .tick    (tick_q),
         .btn_raw (bus.btn_in[i]),
         .level   (level_v[i]),
         .rise    (rise_v[i]),
         .fall    (fall_v[i])
      );
   end

   assign bus.tick      = tick_q;
   assign bus.btn_level = level_v;
   assign bus.btn_rise  = rise_v;
   assign bus.btn_fall  = fall_v;

endmodule

// File: tb/tb_debounce_tick_ctrl.sv
// Purpose : self-checking bench for debounce_tick_ctrl against a window model.
// Latency : n/a.
// Backpressure: n/a.
module tb_debounce_tick_ctrl;
   localparam int DIV = 10;
   localparam int ST  = 3;
   localparam int NCH = 4;

   logic clk_in = 1'b0;
   logic reset  = 1'b1;
   int   n_checks = 0;
   int   n_err    = 0;

   // Reference model: a level flips when the last ST tick samples all
   // disagree with it; samples are the raw input two clocks old.
   int           en_run;
   bit           m_tick;
   bit [NCH-1:0] m_level, m_rise, m_fall, h1, h2;
   bit [ST-1:0]  recent [NCH];

   always #5 clk_in = ~clk_in;

   debounce_tick_ctrl_if #(.NUM_CH(NCH)) bus ();

   debounce_tick_ctrl #(
      .CLK_HZ       (1000),
      .TICK_HZ      (100),
      .NUM_CH       (NCH),
      .STABLE_TICKS (ST)
   ) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus)
   );

   function automatic void model_reset();
      en_run  = 0;
      m_tick  = 1'b0;
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
      h1      = '0;
      h2      = '0;
      for (int c = 0; c < NCH; c++) recent[c] = '0;
   endfunction

   function automatic logic [3*NCH:0] obs_vec();
      return {bus.tick, bus.btn_level, bus.btn_rise, bus.btn_fall};
   endfunction

   function automatic logic [3*NCH:0] mdl_vec();
      return {m_tick, m_level, m_rise, m_fall};
   endfunction

   // Advance one clock and the model with it; returns 1 ns after the edge.
   task automatic step();
      bit [NCH-1:0] samp;
      bit           acted;
      @(posedge clk_in);
      if (reset) begin
         model_reset();
         #1;
         return;
      end
      samp  = h2;
      acted = m_tick;
      h2    = h1;
      h1    = bus.btn_in;
      if (bus.enable) begin
         en_run++;
         m_tick = ((en_run % DIV) == 0);
      end else begin
         en_run = 0;
         m_tick = 1'b0;
      end
      m_rise = '0;
      m_fall = '0;
      if (acted) begin
         for (int c = 0; c < NCH; c++) begin
            recent[c] = {recent[c][ST-2:0], samp[c]};
            if (recent[c] == {ST{~m_level[c]}}) begin
               m_level[c] = ~m_level[c];
               if (m_level[c]) m_rise[c] = 1'b1;
               else            m_fall[c] = 1'b1;
            end
         end
      end
      #1;
   endtask

   // Step until a tick is visible (bounded).
   task automatic align(input string name);
      int k;
      k = 0;
      while (bus.tick !== 1'b1 && k < 3 * DIV) begin
         step();
         k++;
      end
      n_checks++;
      if (bus.tick !== 1'b1) begin
         n_err++;
         $display("FAIL %s_align: no tick within %0d clks (tick=%b)", name, 3 * DIV, bus.tick);
      end
   endtask

   task automatic test_reset();
      bus.btn_in = 4'b1011;
      bus.enable = 1'b1;
      repeat (3) begin
         step();
         n_checks++;
         if (obs_vec() !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", obs_vec());
         end
      end
      bus.btn_in = '0;
      bus.enable = 1'b0;
      reset = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_enable();
      int first, ticks;
      for (int pass = 0; pass < 2; pass++) begin
         bus.enable = 1'b1;
         first = 0;
         for (int k = 1; k <= 3 * DIV && first == 0; k++) begin
            step();
            n_checks++;
            if (obs_vec() !== mdl_vec()) begin
               n_err++;
               $display("FAIL enable_cycle: got %b want %b", obs_vec(), mdl_vec());
            end
            if (bus.tick === 1'b1) first = k;
         end
         n_checks++;
         if (first != DIV) begin
            n_err++;
            $display("FAIL enable_first_tick pass%0d: got %0d clks want %0d", pass, first, DIV);
         end
         repeat (5) step();
         bus.enable = 1'b0;
         ticks = 0;
         repeat (2 * DIV) begin
            step();
            if (bus.tick === 1'b1) ticks++;
         end
         n_checks++;
         if (ticks != 0) begin
            n_err++;
            $display("FAIL enable_off_ticks: got %0d want 0", ticks);
         end
      end
      bus.enable = 1'b1;
   endtask

   task automatic test_clean_press();
      int at;
      for (int dir = 0; dir < 2; dir++) begin
         align("press");
         bus.btn_in[0] = (dir == 0);
         at = 0;
         for (int k = 1; k <= 6 * DIV; k++) begin
            step();
            n_checks++;
            if (obs_vec() !== mdl_vec()) begin
               n_err++;
               $display("FAIL press_cycle k=%0d: got %b want %b", k, obs_vec(), mdl_vec());
            end
            if ((dir == 0 ? bus.btn_rise[0] : bus.btn_fall[0]) === 1'b1) begin
               if (at == 0) at = k;
               else at = -1;
            end
         end
         n_checks++;
         if (at != 3 * DIV + 1) begin
            n_err++;
            $display("FAIL press_edge dir%0d: pulse at clk %0d want %0d (-1 = repeated)", dir, at, 3 * DIV + 1);
         end
         n_checks++;
         if (bus.btn_level[0] !== (dir == 0)) begin
            n_err++;
            $display("FAIL press_level dir%0d: got %b", dir, bus.btn_level[0]);
         end
      end
   endtask

   task automatic test_bounce();
      bit pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      int at, rises, falls, k;
      align("bounce");
      at = 0; rises = 0; falls = 0; k = 0;
      for (int p = 0; p < 8; p++) begin
         bus.btn_in[1] = pat[p];
         repeat (DIV) begin
            step();
            k++;
            n_checks++;
            if (obs_vec() !== mdl_vec()) begin
               n_err++;
               $display("FAIL bounce_cycle k=%0d: got %b want %b", k, obs_vec(), mdl_vec());
            end
            if (bus.btn_rise[1] === 1'b1) begin rises++; if (at == 0) at = k; end
            if (bus.btn_fall[1] === 1'b1) falls++;
         end
      end
      n_checks++;
      if (rises != 1 || falls != 0 || at != 5 * DIV + 11) begin
         n_err++;
         $display("FAIL bounce_pulses: rises=%0d falls=%0d at=%0d want 1 0 %0d", rises, falls, at, 5 * DIV + 11);
      end
   endtask

   task automatic test_glitch();
      int pulses;
      align("glitch");
      step();
      bus.btn_in[2] = 1'b1;
      repeat (5) step();
      bus.btn_in[2] = 1'b0;
      pulses = 0;
      repeat (4 * DIV) begin
         step();
         n_checks++;
         if (obs_vec() !== mdl_vec()) begin
            n_err++;
            $display("FAIL glitch_cycle: got %b want %b", obs_vec(), mdl_vec());
         end
         if (bus.btn_rise[2] === 1'b1 || bus.btn_fall[2] === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != 0 || bus.btn_level[2] !== 1'b0) begin
         n_err++;
         $display("FAIL glitch_effect: pulses=%0d level=%b want 0 0", pulses, bus.btn_level[2]);
      end
   endtask

   task automatic test_simultaneous();
      int at0, at3, other;
      at0 = 0; at3 = 0; other = 0;
      bus.btn_in[0] = 1'b1;
      bus.btn_in[3] = 1'b1;
      for (int k = 1; k <= 6 * DIV; k++) begin
         step();
         n_checks++;
         if (obs_vec() !== mdl_vec()) begin
            n_err++;
            $display("FAIL simul_cycle: got %b want %b", obs_vec(), mdl_vec());
         end
         if (bus.btn_rise[0] === 1'b1 && at0 == 0) at0 = k;
         if (bus.btn_rise[3] === 1'b1 && at3 == 0) at3 = k;
         if ((bus.btn_rise[2:1] | bus.btn_fall[2:1]) !== 2'b00) other++;
      end
      n_checks++;
      if (at0 == 0 || at0 != at3 || other != 0) begin
         n_err++;
         $display("FAIL simul_rise: ch0 at %0d ch3 at %0d other=%0d want equal nonzero, 0", at0, at3, other);
      end
   endtask

   task automatic test_random();
      int c;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 11) == 0) begin
            c = int'($urandom_range(0, NCH - 1));
            bus.btn_in[c] = ~bus.btn_in[c];
         end
         if ($urandom_range(0, 299) == 0) bus.enable = ~bus.enable;
         step();
         n_checks++;
         if (obs_vec() !== mdl_vec()) begin
            n_err++;
            $display("FAIL random_cycle k=%0d: got %b want %b", k, obs_vec(), mdl_vec());
         end
      end
      bus.enable = 1'b1;
   endtask

   task automatic test_reset_mid_pending();
      int at;
      bus.btn_in = '0;
      reset = 1'b1;
      model_reset();
      repeat (2) step();
      reset = 1'b0;
      align("pend");
      bus.btn_in[0] = 1'b1;
      repeat (2 * DIV + 2) step();
      // Two qualifying samples taken; one more tick would complete the press.
      reset = 1'b1;
      model_reset();
      #2;
      n_checks++;
      if (obs_vec() !== '0) begin
         n_err++;
         $display("FAIL pend_async_reset: got %b want 0", obs_vec());
      end
      repeat (2) step();
      reset = 1'b0;
      at = 0;
      for (int k = 1; k <= 5 * DIV && at == 0; k++) begin
         step();
         n_checks++;
         if (obs_vec() !== mdl_vec()) begin
            n_err++;
            $display("FAIL pend_cycle k=%0d: got %b want %b", k, obs_vec(), mdl_vec());
         end
         if (bus.btn_rise[0] === 1'b1) at = k;
      end
      n_checks++;
      if (at != 3 * DIV + 1) begin
         n_err++;
         $display("FAIL pend_requalify: rise at clk %0d want %0d", at, 3 * DIV + 1);
      end
   endtask

   initial begin
      bus.enable = 1'b0;
      bus.btn_in = '0;
      model_reset();
      test_reset();
      test_enable();
      test_clean_press();
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_random();
      test_reset_mid_pending();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
